// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM state encoding and branch target table (used with PC_LUT_EN)
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;
  localparam int LUT_IDX_W = 4;
  localparam int LUT_DEPTH = 1 << LUT_IDX_W;
  // Entry i holds (i+1)*16; entries are truncated to PC_W at the point of use.
  localparam logic [15:0] BRANCH_LUT [LUT_DEPTH] = '{
    16'h0010, 16'h0020, 16'h0030, 16'h0040,
    16'h0050, 16'h0060, 16'h0070, 16'h0080,
    16'h0090, 16'h00A0, 16'h00B0, 16'h00C0,
    16'h00D0, 16'h00E0, 16'h00F0, 16'h0100
  };
endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// branch_lut: combinational branch index to target lookup, built only with PC_LUT_EN
`ifdef PC_LUT_EN
module branch_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);
  // Table entry narrowed to the program-counter width
  always_comb target = PC_W'(BRANCH_LUT[idx]);
endmodule
`endif

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch PC sequencer with IDLE/RUN/HALT FSM; macro PC_LUT_EN selects LUT branch targets
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic [PC_W-1:0]      branch_target,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      addr,
  output logic                 instr_valid,
  output logic                 done,
  output logic [15:0]          fetch_count
);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_HALT = 2'(HALT);
  logic [1:0]      state, state_n;
  logic [PC_W-1:0] addr_n, target;
  logic            valid_n;
  logic [15:0]     count_n, count_inc;
`ifdef PC_LUT_EN
  branch_lut #(.PC_W(PC_W)) u_lut (.idx(branch_idx), .target(target));
  logic unused_target;
  assign unused_target = ^branch_target;
`else
  assign target = branch_target;
  logic unused_idx;
  assign unused_idx = ^branch_idx;
`endif
  assign count_inc = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
  assign done = (state == S_HALT);
  // Next state: start restarts from IDLE/HALT; in RUN halt beats branch beats stall beats increment
  always_comb begin
    state_n = state;
    addr_n  = addr;
    valid_n = instr_valid;
    count_n = fetch_count;
    if (state == S_RUN) begin
      if (halt) begin
        state_n = S_HALT;
        valid_n = 1'b0;
      end else if (branch_en) begin
        addr_n  = target;
        valid_n = 1'b0;
        count_n = count_inc;
      end else if (!stall) begin
        addr_n  = addr + 1'b1;
        valid_n = 1'b1;
        count_n = count_inc;
      end
    end else if (start) begin
      state_n = S_RUN;
      addr_n  = START_ADDR;
      valid_n = 1'b1;
      count_n = 16'd0;
    end else begin
      state_n = (state == S_HALT) ? S_HALT : S_IDLE;
      valid_n = 1'b0;
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr        <= START_ADDR;
      instr_valid <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      instr_valid <= valid_n;
      fetch_count <= count_n;
    end
  end
endmodule
